// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 host transmitter.
package ps2_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_FALL = 10;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    // Odd parity bit: data plus parity together hold an odd number of ones.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 pins and flags falling edges of the PS/2 clock.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_clk_lvl,
    output logic o_data_lvl,
    output logic o_fall
);

    logic [2:0] r_clk_sync;
    logic [1:0] r_data_sync;

    // Shift registers; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    assign o_clk_lvl  = r_clk_sync[1];
    assign o_data_lvl = r_data_sync[1];
    assign o_fall     = r_clk_sync[2] & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one byte with open-drain pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 ps2_clk_low,
    output logic                 ps2_data_low,
    output logic                 done,
    output logic                 ack_err,
    output logic                 timeout_err
);

    localparam int unsigned MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    logic w_clk_lvl;
    logic w_data_lvl;
    logic w_fall;
    logic w_timeout;

    ps2_tx_state_e        r_state,   w_state_n;
    logic [CNT_W-1:0]     r_cnt,     w_cnt_n;
    logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_n;
    logic [DATA_BITS:0]   r_sh,      w_sh_n;
    logic r_clk_low,  w_clk_low_n;
    logic r_data_low, w_data_low_n;
    logic r_done,     w_done_n;
    logic r_ack_err,  w_ack_err_n;
    logic r_tmo_err,  w_tmo_err_n;
    logic r_tx_ready;
    logic r_busy;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst        (clrn),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_clk_lvl  (w_clk_lvl),
        .o_data_lvl (w_data_lvl),
        .o_fall     (w_fall)
    );

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and next-output logic; REQ counts as the first cycle of the timeout window.
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_sh_n       = r_sh;
        w_clk_low_n  = r_clk_low;
        w_data_low_n = r_data_low;
        w_done_n     = 1'b0;
        w_ack_err_n  = r_ack_err;
        w_tmo_err_n  = 1'b0;

        case (r_state)
            IDLE: begin
                w_ack_err_n  = 1'b0;
                w_clk_low_n  = 1'b0;
                w_data_low_n = 1'b0;
                if (tx_valid) begin
                    w_state_n   = INHIBIT;
                    w_cnt_n     = CNT_W'(INHIBIT_CYCLES - 1);
                    w_sh_n      = {odd_parity(tx_data), tx_data};
                    w_clk_low_n = 1'b1;
                end
            end
            INHIBIT: begin
                w_clk_low_n  = 1'b1;
                w_cnt_n      = r_cnt - CNT_W'(1);
                w_data_low_n = (r_cnt == CNT_W'(1));
                if (r_cnt == '0) begin
                    w_state_n    = REQ;
                    w_clk_low_n  = 1'b0;
                    w_data_low_n = 1'b1;
                end
            end
            REQ: begin
                w_clk_low_n  = 1'b0;
                w_data_low_n = 1'b1;
                w_cnt_n      = CNT_W'(1);
                w_bit_cnt_n  = '0;
                w_state_n    = SEND;
            end
            SEND: begin
                w_cnt_n = r_cnt + CNT_W'(1);
                if (w_fall) begin
                    w_bit_cnt_n = r_bit_cnt + BIT_CNT_W'(1);
                    if (r_bit_cnt == BIT_CNT_W'(STOP_FALL - 1)) begin
                        w_data_low_n = 1'b0;
                        w_state_n    = WAIT_ACK;
                    end else begin
                        w_data_low_n = ~r_sh[r_bit_cnt];
                    end
                end
            end
            WAIT_ACK: begin
                w_cnt_n = r_cnt + CNT_W'(1);
                if (w_fall) begin
                    w_ack_err_n = w_data_lvl;
                    w_state_n   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    w_done_n  = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (((r_state == SEND) || (r_state == WAIT_ACK)) && w_timeout) begin
            w_state_n    = IDLE;
            w_clk_low_n  = 1'b0;
            w_data_low_n = 1'b0;
            w_done_n     = 1'b1;
            w_tmo_err_n  = 1'b1;
            w_ack_err_n  = 1'b0;
        end
    end

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_sh       <= '0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_sh       <= w_sh_n;
            r_clk_low  <= w_clk_low_n;
            r_data_low <= w_data_low_n;
            r_done     <= w_done_n;
            r_ack_err  <= w_ack_err_n;
            r_tmo_err  <= w_tmo_err_n;
            r_tx_ready <= (w_state_n == IDLE);
            r_busy     <= (w_state_n != IDLE);
        end
    end

    assign tx_ready     = r_tx_ready;
    assign busy         = r_busy;
    assign ps2_clk_low  = r_clk_low;
    assign ps2_data_low = r_data_low;
    assign done         = r_done;
    assign ack_err      = r_ack_err;
    assign timeout_err  = r_tmo_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a wired-AND bus and a simple device model.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 3000;
    localparam int H   = 30;

    logic       clk;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic       done;
    logic       ack_err;
    logic       timeout_err;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_w;
    logic       ps2_data_w;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic [7:0] data;
        logic       ack;
        logic       par;
        logic       exp_ack_err;
    } vec_t;

    vec_t vecs [6];

    assign ps2_clk_w  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data_w = ~(ps2_data_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .ps2_clk      (ps2_clk_w),
        .ps2_data     (ps2_data_w),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .done         (done),
        .ack_err      (ack_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept a byte and count how long the host holds the clock low.
    task automatic start_and_inhibit(input string nm, input logic [7:0] d, input logic hold);
        int n;
        logic start_seen;
        n = 0;
        start_seen = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (hold) tx_data = ~d;
        else      tx_valid = 1'b0;
        while (ps2_clk_low && n < 4 * INH) begin
            start_seen = ps2_data_low;
            n++;
            @(negedge clk);
        end
        chk({nm, " inhibit_len"}, 32'(n), 32'(INH));
        chk({nm, " start_in_inhibit"}, 32'(start_seen), 32'(1));
    endtask

    // Full transfer with device clocking; device optionally acknowledges.
    task automatic run_xfer(input string nm, input logic [7:0] d, input logic ack,
                            input logic par, input logic exp_ack, input logic hold);
        logic [10:0] frame;
        int n;
        int extra;
        frame = '0;
        start_and_inhibit(nm, d, hold);
        frame[0] = ps2_data_w;
        for (int i = 1; i <= 11; i++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i <= 10) frame[i] = ps2_data_w;
            if (i == 10 && ack) dev_data_low = 1'b1;
            if (i == 11) dev_data_low = 1'b0;
        end
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (hold) tx_valid = 1'b0;
        chk({nm, " done_seen"}, 32'(done), 32'(1));
        chk({nm, " frame"}, 32'(frame), 32'({1'b1, par, d, 1'b0}));
        chk({nm, " ack_err"}, 32'(ack_err), 32'(exp_ack));
        chk({nm, " timeout_err"}, 32'(timeout_err), 32'(0));
        chk({nm, " lines_released"}, 32'({ps2_clk_low, ps2_data_low}), 32'(0));
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(done), 32'(0));
        chk({nm, " tx_ready_after"}, 32'(tx_ready), 32'(1));
        if (hold) begin
            extra = 0;
            repeat (50) begin
                @(negedge clk);
                if (busy || done) extra++;
            end
            chk({nm, " no_second_xfer"}, 32'(extra), 32'(0));
        end
    endtask

    initial begin
        int t;
        n_cmp        = 0;
        n_bad        = 0;
        clrn         = 1'b1;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;

        //           data   ack   par   ack_err
        vecs[0] = {8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = {8'hF4, 1'b1, 1'b0, 1'b0};
        vecs[2] = {8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = {8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = {8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = {8'hED, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset tx_ready", 32'(tx_ready), 32'(1));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset enables", 32'({ps2_clk_low, ps2_data_low}), 32'(0));
        chk("reset flags", 32'({done, ack_err, timeout_err}), 32'(0));
        clrn = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].ack,
                     vecs[v].par, vecs[v].exp_ack_err, 1'b0);
            repeat (5) @(negedge clk);
        end

        // Device never clocks: timeout counted from clock release.
        start_and_inhibit("tmo", 8'hF4, 1'b0);
        t = 0;
        while (!done && t < TMO + 100) begin
            @(negedge clk);
            t++;
        end
        chk("tmo cycles", 32'(t), 32'(TMO));
        chk("tmo timeout_err", 32'(timeout_err), 32'(1));
        chk("tmo ack_err", 32'(ack_err), 32'(0));
        chk("tmo lines_released", 32'({ps2_clk_low, ps2_data_low}), 32'(0));
        @(negedge clk);
        chk("tmo tx_ready", 32'(tx_ready), 32'(1));
        chk("tmo err_cleared", 32'({done, timeout_err}), 32'(0));
        repeat (5) @(negedge clk);

        // tx_valid held with changing data during the transfer.
        run_xfer("hold", 8'hED, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);

        // Reset while bit 4 (a zero) is being driven.
        start_and_inhibit("rst", 8'hED, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i < 5) begin
                repeat (H) @(negedge clk);
                dev_clk_low = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        chk("rst busy_before", 32'(busy), 32'(1));
        chk("rst data_low_before", 32'(ps2_data_low), 32'(1));
        #1;
        clrn = 1'b1;
        #1;
        chk("rst enables_async", 32'({ps2_clk_low, ps2_data_low}), 32'(0));
        chk("rst idle_async", 32'({tx_ready, busy}), 32'(2));
        dev_clk_low = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        repeat (5) @(negedge clk);
        run_xfer("post_rst", 8'hED, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
